// File: rtl/xbar_bb_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined
// basic-block crossbar (radix, stage counts, default pipe mask).
package xbar_bb_pipe_pkg;

  localparam int BB_RADIX_DEF = 2;
  localparam int BB_LG_DEF    = 1;
  localparam int N_IN_DEF     = 16;
  localparam int N_STG_DEF    = 4;

  // Default pipe mask: every stage registered. Sliced to N_STG.
  localparam logic [31:0] PIPE_MASK_ALL = '1;
  localparam logic [N_STG_DEF-1:0] PIPE_MASK_DEF =
    PIPE_MASK_ALL[N_STG_DEF-1:0];

  // Select bits consumed by one basic block.
  // Illegal radices map to 1 so widths stay sane until the
  // elaboration check in the top fires.
  function automatic int bb_lg(input int r);
    return (r == 4) ? 2 : 1;
  endfunction

  function automatic int n_stg(input int n, input int r);
    int s;
    s = $clog2(n) / bb_lg(r);
    return (s < 1) ? 1 : s;
  endfunction

  function automatic bit is_pow(input int n, input int r);
    int x;
    if (n < r || r < 2) return 1'b0;
    x = n;
    while (x > 1 && (x % r) == 0) x = x / r;
    return (x == 1);
  endfunction

  // Nodes present at tree level l (level 0 = the bank inputs).
  function automatic int lvl_cnt(input int n, input int r,
                                 input int l);
    return n / (r ** l);
  endfunction

  // Basic blocks in stage s of one output tree.
  function automatic int bb_count(input int n, input int r,
                                  input int s);
    return lvl_cnt(n, r, s + 1);
  endfunction

  // Offset of level l in a flat per-tree node array.
  function automatic int lvl_off(input int n, input int r,
                                 input int l);
    int o;
    o = 0;
    for (int t = 0; t < l; t++) o += lvl_cnt(n, r, t);
    return o;
  endfunction

endpackage

// File: rtl/xbar_bb.sv
// One basic block: combinational BB_RADIX-to-1 mux of {valid, data}.
// Ports: v_i/d_i lane inputs, sel_i lane index, v_o/d_o result.
module xbar_bb
  import xbar_bb_pipe_pkg::*;
#(
  parameter int BB_RADIX = BB_RADIX_DEF,
  parameter int DATA_W   = 32,
  localparam int LG      = bb_lg(BB_RADIX)
) (
  input  logic [BB_RADIX-1:0]             v_i,
  input  logic [BB_RADIX-1:0][DATA_W-1:0] d_i,
  input  logic [LG-1:0]                   sel_i,
  output logic                            v_o,
  output logic [DATA_W-1:0]               d_o
);

  assign v_o = v_i[sel_i];
  assign d_o = d_i[sel_i];

endmodule

// File: rtl/xbar_bb_pipe.sv
// Bank-to-PE crossbar built as per-output trees of basic blocks,
// with an optional register after each stage (PIPE_MASK).
// Ports: clk_i, rst_n_i (async low), en_i advance, flush_i kills
// in-flight valids, data_i/valid_i bank side, sel_i per-output
// source index, data_o/valid_o PE side.
module xbar_bb_pipe
  import xbar_bb_pipe_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int N_OUT    = 16,
  parameter int BB_RADIX = BB_RADIX_DEF,
  parameter int DATA_W   = 32,
  parameter logic [n_stg(N_IN, BB_RADIX)-1:0] PIPE_MASK =
    PIPE_MASK_ALL[n_stg(N_IN, BB_RADIX)-1:0]
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              en_i,
  input  logic                              flush_i,
  input  logic [N_IN-1:0][DATA_W-1:0]       data_i,
  input  logic [N_IN-1:0]                   valid_i,
  input  logic [N_OUT-1:0][$clog2(N_IN)-1:0] sel_i,
  output logic [N_OUT-1:0][DATA_W-1:0]      data_o,
  output logic [N_OUT-1:0]                  valid_o
);

  localparam int LG    = bb_lg(BB_RADIX);
  localparam int N_STG = n_stg(N_IN, BB_RADIX);
  localparam int SEL_W = $clog2(N_IN);
  localparam int TOT   = lvl_off(N_IN, BB_RADIX, N_STG + 1);

  if (!(BB_RADIX == 2 || BB_RADIX == 4)) begin : g_bad_radix
    $error("xbar_bb_pipe: BB_RADIX must be 2 or 4");
  end
  if (!is_pow(N_IN, BB_RADIX)) begin : g_bad_nin
    $error("xbar_bb_pipe: N_IN must be a power of BB_RADIX");
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    // Flat node storage for the whole tree, level by level.
    logic [TOT-1:0]    lv_v;
    logic [DATA_W-1:0] lv_d [TOT];
    // Select travelling with the beat into stage s.
    logic [SEL_W-1:0]  lv_s [N_STG];

    assign lv_v[N_IN-1:0] = valid_i;
    assign lv_s[0]        = sel_i[j];
    for (genvar k = 0; k < N_IN; k++) begin : g_in
      assign lv_d[k] = data_i[k];
    end

    for (genvar s = 0; s < N_STG; s++) begin : g_stg
      localparam int CNT = bb_count(N_IN, BB_RADIX, s);
      localparam int IO  = lvl_off(N_IN, BB_RADIX, s);
      localparam int OO  = lvl_off(N_IN, BB_RADIX, s + 1);

      logic [LG-1:0]     bsel;
      logic [CNT-1:0]    m_v;
      logic [DATA_W-1:0] m_d [CNT];

      // Stage s consumes select slice s, LSB slice first.
      assign bsel = lv_s[s][s*LG +: LG];

      // Slices already consumed upstream ride along but are dead.
      if (s > 0) begin : g_sink
        logic sel_unused;
        assign sel_unused = ^lv_s[s][s*LG-1:0];
      end

      for (genvar k = 0; k < CNT; k++) begin : g_bb
        logic [BB_RADIX-1:0]             bv;
        logic [BB_RADIX-1:0][DATA_W-1:0] bd;
        for (genvar r = 0; r < BB_RADIX; r++) begin : g_ln
          assign bv[r] = lv_v[IO + k*BB_RADIX + r];
          assign bd[r] = lv_d[IO + k*BB_RADIX + r];
        end
        xbar_bb #(
          .BB_RADIX (BB_RADIX),
          .DATA_W   (DATA_W)
        ) u_bb (
          .v_i   (bv),
          .d_i   (bd),
          .sel_i (bsel),
          .v_o   (m_v[k]),
          .d_o   (m_d[k])
        );
      end

      if (PIPE_MASK[s]) begin : g_reg
        logic [CNT-1:0]    v_d, v_q;
        logic [DATA_W-1:0] d_d [CNT];
        logic [DATA_W-1:0] d_q [CNT];

        // Flush overrides advance, but only for valids.
        always_comb begin
          v_d = v_q;
          d_d = d_q;
          if (en_i) begin
            v_d = m_v;
            d_d = m_d;
          end
          if (flush_i) v_d = '0;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
          if (!rst_n_i) begin
            v_q <= '0;
            d_q <= '{default: '0};
          end else begin
            v_q <= v_d;
            d_q <= d_d;
          end
        end

        assign lv_v[OO +: CNT] = v_q;
        for (genvar k = 0; k < CNT; k++) begin : g_o
          assign lv_d[OO + k] = d_q[k];
        end

        if (s < N_STG - 1) begin : g_sel
          logic [SEL_W-1:0] s_d, s_q;
          assign s_d = en_i ? lv_s[s] : s_q;
          always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) s_q <= '0;
            else          s_q <= s_d;
          end
          assign lv_s[s+1] = s_q;
        end
      end else begin : g_cmb
        assign lv_v[OO +: CNT] = m_v;
        for (genvar k = 0; k < CNT; k++) begin : g_o
          assign lv_d[OO + k] = m_d[k];
        end
        if (s < N_STG - 1) begin : g_sel
          assign lv_s[s+1] = lv_s[s];
        end
      end
    end

    assign valid_o[j] = lv_v[TOT-1];
    assign data_o[j]  = lv_d[TOT-1];
  end

endmodule

// File: tb/tb_xbar_bb_pipe.sv
// Bench for xbar_bb_pipe: 8x8 radix-2, full mask (latency 3) and
// mask 3'b010 (latency 1) side by side on shared stimulus.
module tb_xbar_bb_pipe;

  typedef logic [7:0][31:0] dvec_t;
  typedef logic [7:0][2:0]  svec_t;

  typedef struct {
    logic [7:0] v;
    dvec_t      d;
    svec_t      s;
  } beat_t;

  typedef struct {
    logic [7:0]  v;
    dvec_t       d;
    svec_t       s;
    logic [7:0]  ev;
    logic [31:0] ed0;
    logic [31:0] ed7;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  dvec_t      data_in;
  logic [7:0] valid_in;
  svec_t      sel_in;
  dvec_t      dA, dB;
  logic [7:0] vA, vB;

  always #5 clk = ~clk;

  xbar_bb_pipe #(
    .N_IN(8), .N_OUT(8), .BB_RADIX(2), .DATA_W(32),
    .PIPE_MASK(3'b111)
  ) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .flush_i(flush),
    .data_i(data_in), .valid_i(valid_in), .sel_i(sel_in),
    .data_o(dA), .valid_o(vA)
  );

  xbar_bb_pipe #(
    .N_IN(8), .N_OUT(8), .BB_RADIX(2), .DATA_W(32),
    .PIPE_MASK(3'b010)
  ) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .flush_i(flush),
    .data_i(data_in), .valid_i(valid_in), .sel_i(sel_in),
    .data_o(dB), .valid_o(vB)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Reference: beats captured on enabled edges; output is the
  // beat captured lat[i] enabled edges ago, routed by its selects.
  int    lat [2] = '{3, 1};
  beat_t hist [2][3];
  vec_t  tbl [4];

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        hist[i][k].v = '0;
        hist[i][k].d = '0;
        hist[i][k].s = '0;
      end
  endtask

  task automatic model_edge();
    beat_t nb;
    nb.v = flush ? 8'h00 : valid_in;
    nb.d = data_in;
    nb.s = sel_in;
    for (int i = 0; i < 2; i++) begin
      if (flush)
        for (int k = 0; k < 3; k++) hist[i][k].v = '0;
      if (en) begin
        for (int k = lat[i] - 1; k > 0; k--)
          hist[i][k] = hist[i][k-1];
        hist[i][0] = nb;
      end
    end
  endtask

  task automatic check_dut(input int i, input string nm);
    beat_t      b;
    logic [7:0] ev, av;
    dvec_t      ed, ad;
    int         bad;
    b   = hist[i][lat[i]-1];
    av  = (i == 0) ? vA : vB;
    ad  = (i == 0) ? dA : dB;
    bad = -1;
    for (int j = 0; j < 8; j++) begin
      ev[j] = b.v[b.s[j]];
      ed[j] = b.d[b.s[j]];
    end
    for (int j = 0; j < 8; j++)
      if (ev[j] && ad[j] !== ed[j] && bad < 0) bad = j;
    tests++;
    if (av !== ev || bad >= 0) begin
      fails++;
      if (bad < 0) bad = 0;
      $display("FAIL %s dut%0d cyc %0d: valid_o=%h data_o[%0d]=%h, want valid_o=%h data=%h",
               nm, i, cyc, av, bad, ad[bad], ev, ed[bad]);
    end
  endtask

  task automatic check_eq(input string nm, input logic [63:0] got,
                          input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got %h, want %h", nm, cyc, got, exp);
    end
  endtask

  task automatic check_tbl(input string nm, input int t,
                           input logic [7:0] av, input dvec_t ad);
    bit ok;
    ok = (av === tbl[t].ev);
    if (tbl[t].ev[0] && ad[0] !== tbl[t].ed0) ok = 1'b0;
    if (tbl[t].ev[7] && ad[7] !== tbl[t].ed7) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s[%0d]: valid_o=%h d0=%h d7=%h, want %h %h %h",
               nm, t, av, ad[0], ad[7], tbl[t].ev, tbl[t].ed0,
               tbl[t].ed7);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    cyc++;
    #2;
    check_dut(0, "model");
    check_dut(1, "model");
  endtask

  task automatic idle();
    valid_in = '0;
    for (int k = 0; k < 8; k++) data_in[k] = $urandom;
    for (int j = 0; j < 8; j++) sel_in[j] = 3'($urandom_range(0, 7));
  endtask

  initial begin
    // Identity routing.
    tbl[0].v = 8'hFF; tbl[0].ev = 8'hFF;
    tbl[0].ed0 = 32'h100; tbl[0].ed7 = 32'h107;
    // Broadcast of bank 5; only bank 5 valid.
    tbl[1].v = 8'h20; tbl[1].ev = 8'hFF;
    tbl[1].ed0 = 32'hDEADBEEF; tbl[1].ed7 = 32'hDEADBEEF;
    // Reversed routing, low banks valid.
    tbl[2].v = 8'h0F; tbl[2].ev = 8'hF0;
    tbl[2].ed0 = 32'h0; tbl[2].ed7 = 32'h200;
    // Stride-3 permutation, sparse valids.
    tbl[3].v = 8'hA5; tbl[3].ev = 8'hE1;
    tbl[3].ed0 = 32'h0; tbl[3].ed7 = 32'h05050505;
    for (int k = 0; k < 8; k++) begin
      tbl[0].d[k] = 32'h100 + k;
      tbl[0].s[k] = 3'(k);
      tbl[1].d[k] = (k == 5) ? 32'hDEADBEEF : 32'h300 + k;
      tbl[1].s[k] = 3'd5;
      tbl[2].d[k] = 32'h200 + k;
      tbl[2].s[k] = 3'(7 - k);
      tbl[3].d[k] = 32'h01010101 * k;
      tbl[3].s[k] = 3'((k * 3) % 8);
    end

    data_in = '0; valid_in = '0; sel_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_validA", 64'(vA), 64'h0);
    check_eq("rst_validB", 64'(vB), 64'h0);
    check_eq("rst_dataA", 64'(|dA), 64'h0);
    check_eq("rst_dataB", 64'(|dB), 64'h0);
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    for (int t = 0; t < 4; t++) begin
      valid_in = tbl[t].v;
      data_in  = tbl[t].d;
      sel_in   = tbl[t].s;
      en = 1'b1; flush = 1'b0;
      tick();
      check_tbl("tblB", t, vB, dB);
      idle();
      tick();
      tick();
      check_tbl("tblA", t, vA, dA);
    end

    // Stall: beat then two held cycles.
    valid_in = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      data_in[k] = 32'h400 + k;
      sel_in[k]  = 3'(k ^ 1);
    end
    tick();
    idle();
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    check_eq("stall_early", 64'(vA), 64'h0);
    tick();
    check_eq("stall_valid", 64'(vA), 64'hFF);
    check_eq("stall_d0", 64'(dA[0]), 64'h401);
    tick();
    check_eq("stall_nodup", 64'(vA), 64'h0);

    // Flush after three valid beats; flush beats a same-cycle beat.
    for (int c = 0; c < 3; c++) begin
      idle();
      valid_in = 8'hFF;
      tick();
    end
    flush = 1'b1;
    valid_in = 8'hFF;
    tick();
    check_eq("flush_A", 64'(vA), 64'h0);
    check_eq("flush_B", 64'(vB), 64'h0);
    flush = 1'b0;
    idle();
    tick();
    tick();
    check_eq("flush_hold", 64'(vA), 64'h0);

    // Per-beat select change on output 0.
    valid_in = 8'hFF;
    for (int k = 0; k < 8; k++) data_in[k] = 32'h500 + k;
    sel_in[0] = 3'd1;
    tick();
    for (int k = 0; k < 8; k++) data_in[k] = 32'h600 + k;
    sel_in[0] = 3'd6;
    tick();
    idle();
    tick();
    check_eq("selchg_b0", 64'(dA[0]), 64'h501);
    tick();
    check_eq("selchg_b1", 64'(dA[0]), 64'h606);

    // Reset asserted mid-stream.
    for (int c = 0; c < 2; c++) begin
      idle();
      valid_in = 8'hFF;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_eq("mrst_vA", 64'(vA), 64'h0);
    check_eq("mrst_vB", 64'(vB), 64'h0);
    model_reset();
    tick();
    rst_n = 1'b1;
    valid_in = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      data_in[k] = 32'h700 + k;
      sel_in[k]  = 3'(k);
    end
    tick();
    check_eq("mrst_B_lat1", 64'(vB), 64'hFF);
    idle();
    tick();
    check_eq("mrst_A_early", 64'(vA), 64'h0);
    tick();
    check_eq("mrst_A_lat3", 64'(vA), 64'hFF);
    check_eq("mrst_A_d3", 64'(dA[3]), 64'h703);

    // Randomised traffic with stalls and flushes.
    for (int c = 0; c < 400; c++) begin
      idle();
      valid_in = 8'($urandom);
      en       = ($urandom_range(0, 4) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xbar_bb_pipe.md
XBAR_BB_PIPE -- requirements
Module: xbar_bb_pipe

Interface
REQ-001 SHALL expose parameter N_IN, default 16: number of bank-side inputs; a power of BB_RADIX.
REQ-002 SHALL expose parameter N_OUT, default 16: number of PE-side outputs.
REQ-003 SHALL expose parameter BB_RADIX, default 2: mux width of one basic block; only 2 and 4 are legal.
REQ-004 SHALL expose parameter DATA_W, default 32: data width per lane.
REQ-005 SHALL expose parameter PIPE_MASK, default all ones, width N_STG: bit s set means stage s output is registered.
REQ-006 SHALL have port clk_i, input, width 1: the single clock.
REQ-007 SHALL have port rst_n_i, input, width 1: reset, asynchronous, active-low.
REQ-008 SHALL have port en_i, input, width 1: pipeline advance; when low, all stage registers hold.
REQ-009 SHALL have port flush_i, input, width 1: clear all in-flight valids.
REQ-010 SHALL have port data_i, input, N_IN x DATA_W: bank read data.
REQ-011 SHALL have port valid_i, input, N_IN: per-bank valid.
REQ-012 SHALL have port sel_i, input, N_OUT x log2(N_IN): per-output source bank index, sampled with the data.
REQ-013 SHALL have port data_o, output, N_OUT x DATA_W: selected data.
REQ-014 SHALL have port valid_o, output, N_OUT: selected valid.

Function
REQ-015 SHALL compute N_STG = log2(N_IN)/log2(BB_RADIX) stages per output tree; stage 0 SHALL consume the least-significant log2(BB_RADIX) select bits.
REQ-016 SHALL give stage s of each output N_IN/BB_RADIX^(s+1) BB_RADIX-to-1 muxes carrying {valid, data}.
REQ-017 SHALL carry the unused select slices alongside the data through every registered stage, so each stage always uses the select of its own beat.
REQ-018 SHALL make latency equal popcount(PIPE_MASK) cycles; with PIPE_MASK = 0 the block is purely combinational.
REQ-019 SHALL set valid_o[j] to valid_i[sel_i[j]] delayed by the latency; data_o[j] SHALL be the matching delayed data_i[sel_i[j]].
REQ-020 SHALL load registered stages only when en_i = 1; when en_i = 0, data, valid and select registers SHALL hold.
REQ-021 SHALL, when flush_i = 1, clear every registered valid on the next clock edge regardless of en_i; data registers SHALL be unchanged.
REQ-022 SHALL, when flush_i and en_i are both 1, let flush win: no beat sampled that cycle survives.
REQ-023 SHALL let several outputs select the same input (broadcast) with no arbitration and no stall.
REQ-024 SHALL leave data_o unconstrained while valid_o = 0; checkers SHALL compare data only when valid is high.
REQ-025 SHALL reject illegal parameters (BB_RADIX not 2 or 4, N_IN not a power of BB_RADIX) with an elaboration-time error.

Reset
REQ-026 SHALL clear all valid registers on rst_n_i low, asynchronously, so valid_o = 0 during reset.
REQ-027 SHALL clear data and select registers to 0 on reset, so data_o = 0 after reset until the first beat.
REQ-028 SHALL, on reset asserted mid-stream, discard all in-flight beats; the first beat after release SHALL appear after the full latency.

Structure
REQ-029 SHALL have the shared package hold BB_RADIX, the log2 of BB_RADIX, N_STG, per-stage basic-block counts (generalising the fixed stage-0/1/2 counts) and the default PIPE_MASK.
REQ-030 SHALL place one sub-module, xbar_bb, per basic block: a combinational BB_RADIX-to-1 mux of {valid, data}; registers SHALL stay in xbar_bb_pipe.
REQ-031 SHALL size the implementation at 120-400 lines of RTL.

Verification (N_IN = N_OUT = 8, BB_RADIX = 2, DATA_W = 32, PIPE_MASK = 3'b111, latency 3)
REQ-032 SHALL cover identity routing: sel_i[j] = j, data_i[k] = 0x100+k, valid all 1 at cycle 0 -> data_o[j] = 0x100+j, valid_o = 0xFF at cycle 3.
REQ-033 SHALL cover broadcast: all sel_i = 5, data_i[5] = 0xDEADBEEF -> all outputs 0xDEADBEEF, valid_o = 0xFF after 3 cycles.
REQ-034 SHALL cover stall: a beat at cycle 0, en_i low in cycles 1-2 -> the beat appears at cycle 5 with the correct select; no beat is duplicated or dropped.
REQ-035 SHALL cover flush: valid beats in cycles 0-2, flush_i at cycle 3 -> valid_o = 0 from cycle 4 until new beats arrive.
REQ-036 SHALL cover a per-cycle select change: sel_i[0] = 1 then 6 in consecutive cycles -> data_o[0] = data_i[1] of beat 0, then data_i[6] of beat 1.
REQ-037 SHALL cover the reduced mask: a second build with PIPE_MASK = 3'b010 gives latency 1; reset asserted mid-stream gives valid_o = 0 immediately.
